// File: rtl/rtc_seq_lectura_escritura.sv
// Self-sequencing RTC burst sequencer: one optional command-register access, then
// N_REGS address/data pairs, each phase advanced by a bus_ack from the bus-timing block.
module rtc_seq_lectura_escritura #(
   parameter int N_REGS    = 9,
   parameter int ADDR_W    = 4,
   parameter int SEL_W     = 4,
   parameter int BASE_ADDR = 4,
   parameter int CMD_ADDR  = 13,
   parameter int CMD_EN    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              wr_req,
   input  logic              bus_ack,
   output logic              Fin,
   output logic              Op,
   output logic              I,
   output logic              AD,
   output logic              RW,
   output logic [ADDR_W-1:0] Addr,
   output logic [SEL_W-1:0]  sel_reg,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_REGS - 1);
   localparam logic [ADDR_W-1:0] CMD_ADDR_V = ADDR_W'(CMD_ADDR);
   localparam logic [ADDR_W-1:0] BASE_V     = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD_A,
      S_CMD_D,
      S_REG_A,
      S_REG_D,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mode_q, mode_d;
   logic [ADDR_W-1:0] reg_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
      end
   end

   // Address arithmetic wraps modulo 2^ADDR_W by construction of the operand widths.
   assign reg_addr = BASE_V + ADDR_W'(idx_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;

      Fin     = 1'b0;
      Op      = 1'b0;
      I       = 1'b0;
      AD      = 1'b0;
      RW      = mode_q;
      Addr    = '0;
      sel_reg = '0;
      busy    = 1'b1;
      done    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            Fin  = 1'b1;
            RW   = 1'b0;
            busy = 1'b0;
            if (start) begin
               mode_d  = wr_req;
               idx_d   = '0;
               state_d = (CMD_EN != 0) ? S_CMD_A : S_REG_A;
            end
         end
         S_CMD_A: begin
            Op      = 1'b1;
            I       = 1'b1;
            Addr    = CMD_ADDR_V;
            sel_reg = '1;
            if (bus_ack) state_d = S_CMD_D;
         end
         S_CMD_D: begin
            I       = 1'b1;
            AD      = 1'b1;
            Addr    = CMD_ADDR_V;
            sel_reg = '1;
            if (bus_ack) state_d = S_REG_A;
         end
         S_REG_A: begin
            Op      = 1'b1;
            I       = 1'b1;
            Addr    = reg_addr;
            sel_reg = SEL_W'(idx_q);
            if (bus_ack) state_d = S_REG_D;
         end
         S_REG_D: begin
            I       = 1'b1;
            AD      = 1'b1;
            Addr    = reg_addr;
            sel_reg = SEL_W'(idx_q);
            if (bus_ack) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_REG_A;
               end
            end
         end
         S_FIN: begin
            Fin     = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            Fin     = 1'b1;
            RW      = 1'b0;
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rtc_seq_lectura_escritura.sv
// Scoreboard bench: each start pushes the expected per-phase output words, and every cycle
// the active DUT's outputs are compared against the queue head (idle word when empty).
module tb_rtc_seq_lectura_escritura;

   logic clk = 1'b0;
   logic reset;
   logic wr_req;
   logic start_a, ack_a, start_b, ack_b;

   logic fin_a, op_a, i_a, ad_a, rw_a, busy_a, done_a;
   logic [3:0] addr_a, sel_a;
   logic fin_b, op_b, i_b, ad_b, rw_b, busy_b, done_b;
   logic [3:0] addr_b, sel_b;

   always #5 clk = ~clk;

   rtc_seq_lectura_escritura dut_a (
      .clk(clk), .reset(reset), .start(start_a), .wr_req(wr_req), .bus_ack(ack_a),
      .Fin(fin_a), .Op(op_a), .I(i_a), .AD(ad_a), .RW(rw_a),
      .Addr(addr_a), .sel_reg(sel_a), .busy(busy_a), .done(done_a)
   );

   rtc_seq_lectura_escritura #(.N_REGS(3), .BASE_ADDR(2), .CMD_EN(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .wr_req(wr_req), .bus_ack(ack_b),
      .Fin(fin_b), .Op(op_b), .I(i_b), .AD(ad_b), .RW(rw_b),
      .Addr(addr_b), .sel_reg(sel_b), .busy(busy_b), .done(done_b)
   );

   // Word layout: fin op i ad rw busy done addr[3:0] sel[3:0]
   logic [14:0] obs_a, obs_b;
   assign obs_a = {fin_a, op_a, i_a, ad_a, rw_a, busy_a, done_a, addr_a, sel_a};
   assign obs_b = {fin_b, op_b, i_b, ad_b, rw_b, busy_b, done_b, addr_b, sel_b};

   logic [14:0] sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    done_cnt;
   int    busy_cnt;
   logic  sel_dut = 1'b0;
   string tag;

   function automatic logic [14:0] mk(input logic fin, input logic op, input logic i,
                                      input logic ad, input logic rw, input logic bsy,
                                      input logic dn, input logic [3:0] addr,
                                      input logic [3:0] sel);
      return {fin, op, i, ad, rw, bsy, dn, addr, sel};
   endfunction

   task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push_burst(input logic wr);
      int n;
      int base;
      logic cmd;
      cmd  = (sel_dut == 1'b0);
      n    = sel_dut ? 3 : 9;
      base = sel_dut ? 2 : 4;
      if (cmd) begin
         sb_q.push_back(mk(0, 1, 1, 0, wr, 1, 0, 4'd13, 4'd15));
         sb_q.push_back(mk(0, 0, 1, 1, wr, 1, 0, 4'd13, 4'd15));
      end
      for (int k = 0; k < n; k++) begin
         sb_q.push_back(mk(0, 1, 1, 0, wr, 1, 0, 4'(base + k), 4'(k)));
         sb_q.push_back(mk(0, 0, 1, 1, wr, 1, 0, 4'(base + k), 4'(k)));
      end
      sb_q.push_back(mk(1, 0, 0, 0, wr, 1, 1, 4'd0, 4'd0));
   endtask

   // One clock: check current outputs, then drive inputs for the coming edge and
   // advance the scoreboard the way those inputs should move the sequencer.
   task automatic cycle(input logic st, input logic wr, input logic ack, input logic rst);
      logic [14:0] obs;
      logic [14:0] exp;
      @(negedge clk);
      obs = sel_dut ? obs_b : obs_a;
      exp = (sb_q.size() == 0) ? mk(1, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0) : sb_q[0];
      check(tag, obs, exp);
      if (obs[8]) done_cnt++;
      if (obs[9]) busy_cnt++;
      start_a = st & ~sel_dut;
      start_b = st & sel_dut;
      ack_a   = ack & ~sel_dut;
      ack_b   = ack & sel_dut;
      wr_req  = wr;
      reset   = rst;
      if (rst) sb_q.delete();
      else if (sb_q.size() != 0) begin
         if (sb_q[0][8] || ack) void'(sb_q.pop_front());
      end else if (st) push_burst(wr);
   endtask

   task automatic clear_counts(input string name);
      tag      = name;
      done_cnt = 0;
      busy_cnt = 0;
   endtask

   initial begin
      reset = 1'b1; wr_req = 1'b0;
      start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
      repeat (3) @(posedge clk);

      // Idle after reset, bus_ack noise must be ignored
      clear_counts("idle");
      for (int k = 0; k < 10; k++) cycle(0, 0, 1'($urandom % 2), 0);
      check("idle_done", 15'(done_cnt), 15'd0);
      $display("[TB] idle: 10 cycles");

      // Read burst, bus_ack held high
      clear_counts("rd_burst");
      cycle(1, 0, 1, 0);
      for (int k = 0; k < 60 && sb_q.size() != 0; k++) cycle(0, 0, 1, 0);
      check("rd_drain", 15'(sb_q.size()), 15'd0);
      check("rd_done", 15'(done_cnt), 15'd1);
      check("rd_len", 15'(busy_cnt), 15'd21);
      cycle(0, 0, 1, 0);
      $display("[TB] read burst: %0d busy cycles", busy_cnt);

      // Write burst, ack every third cycle, wr_req toggling mid-burst
      clear_counts("wr_slow");
      cycle(1, 1, 0, 0);
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) cycle(0, 1'(k % 2), 1'(k % 3 == 2), 0);
      check("wr_drain", 15'(sb_q.size()), 15'd0);
      check("wr_done", 15'(done_cnt), 15'd1);
      check("wr_len", 15'(busy_cnt), 15'd61);
      cycle(0, 0, 0, 0);
      $display("[TB] write burst: %0d busy cycles", busy_cnt);

      // Reset while in REG_D with idx=5, then a clean restart
      clear_counts("rst_mid");
      cycle(1, 0, 1, 0);
      for (int k = 0; k < 13; k++) cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 0, 0);
      check("rst_no_done", 15'(done_cnt), 15'd0);
      tag = "rst_restart";
      cycle(1, 1, 1, 0);
      for (int k = 0; k < 60 && sb_q.size() != 0; k++) cycle(0, 0, 1, 0);
      check("rst_drain", 15'(sb_q.size()), 15'd0);
      check("rst_done", 15'(done_cnt), 15'd1);
      $display("[TB] reset mid-burst and restart");

      // start held high through the burst and FIN must not queue a second burst
      clear_counts("start_spam");
      cycle(1, 0, 1, 0);
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) cycle(1, 1, 1'($urandom % 2), 0);
      check("spam_drain", 15'(sb_q.size()), 15'd0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      check("spam_done", 15'(done_cnt), 15'd1);
      $display("[TB] start spam: %0d done pulses", done_cnt);

      // Small instance: no command access, 3 registers from address 2
      sel_dut = 1'b1;
      clear_counts("small");
      cycle(1, 0, 1, 0);
      for (int k = 0; k < 30 && sb_q.size() != 0; k++) cycle(0, 0, 1, 0);
      check("small_drain", 15'(sb_q.size()), 15'd0);
      check("small_len", 15'(busy_cnt), 15'd7);
      check("small_done", 15'(done_cnt), 15'd1);
      clear_counts("small_wr");
      cycle(1, 1, 0, 0);
      for (int k = 0; k < 100 && sb_q.size() != 0; k++) cycle(0, 0, 1'($urandom % 2), 0);
      check("small_wr_drain", 15'(sb_q.size()), 15'd0);
      check("small_wr_done", 15'(done_cnt), 15'd1);
      cycle(0, 0, 0, 0);
      $display("[TB] small instance bursts");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
